// File: rtl/seg_pkg.sv
// seg_pkg: constants and state encoding shared by the BCD converter and the seven-segment display controller.
package seg_pkg;
    localparam int SEG_DIGITS = 6;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam logic [4*SEG_DIGITS-1:0] ALL_NINES = {SEG_DIGITS{4'h9}};
    function automatic logic [63:0] max_value(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < digits; k++) p = p * 64'd10;
        return p - 64'd1;
    endfunction
    localparam logic [63:0] MAX_VAL = max_value(SEG_DIGITS);
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble correction cell; a nibble of 5..9 becomes 8..12 so the next shift carries into the next digit.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bcd_converter.sv
// bcd_converter: sequential binary-to-BCD (shift-and-add-3, one bit per clock) with registered digits and a done pulse.
module bcd_converter
    import seg_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int DIGITS = SEG_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);
    localparam int SW = 4*DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};
    localparam logic [63:0] MAX_D = max_value(DIGITS);
    state_t               state_q;
    logic [SW-1:0]        scratch_q, adj, shifted_d;
    logic [CW-1:0]        cnt_q;
    logic                 ovf_next_q, busy_q, done_q, ovf_q;
    logic [4*DIGITS-1:0]  bcd_q;
    assign adj[WIDTH-1:0] = scratch_q[WIDTH-1:0];
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i(scratch_q[WIDTH+4*i +: 4]),
            .q_o(adj[WIDTH+4*i +: 4])
        );
    end
    assign shifted_d = {adj[SW-2:0], 1'b0};
    // Outputs are loaded on the final shift so they appear exactly in the DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        scratch_q  <= {{(4*DIGITS){1'b0}}, bin};
                        cnt_q      <= '0;
                        ovf_next_q <= 64'(bin) > MAX_D;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    scratch_q <= shifted_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= ovf_next_q ? NINES : shifted_d[SW-1 -: 4*DIGITS];
                        ovf_q   <= ovf_next_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: table, random and hand-sequenced checks of bcd_converter against an arithmetic reference model.
module tb_bcd_converter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [19:0] bin = '0;
    logic        busy, done, ovf;
    logic [23:0] bcd;
    int vectors = 0;
    int miscompares = 0;

    bcd_converter dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] b;
        logic [23:0] e;
        logic        o;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal digits by division; anything above 999999 saturates to all nines.
    function automatic logic [24:0] ref_model(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return {1'b1, 24'h999999};
        x = v;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [19:0] v, input string name);
        int cyc, busy_cnt, overlap;
        logic [24:0] exp;
        exp = ref_model(32'(v));
        start = 1'b1;
        bin = v;
        tick();
        start = 1'b0;
        bin = 20'($urandom);
        cyc = 1;
        busy_cnt = 0;
        overlap = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        if (busy && done) overlap = 1;
        check({name, " latency"}, 64'(cyc), 64'd21);
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'd20);
        check({name, " busy_and_done"}, 64'(overlap), 64'd0);
        check({name, " bcd"}, 64'(bcd), 64'(exp[23:0]));
        check({name, " ovf"}, 64'(ovf), 64'(exp[24]));
        tick();
        check({name, " done_width"}, 64'(done), 64'd0);
        check({name, " bcd_hold"}, 64'(bcd), 64'(exp[23:0]));
    endtask

    initial begin
        int dn, last_t, n_done;
        logic [19:0] r;
        tbl[0] = '{20'd0,       24'h000000, 1'b0};
        tbl[1] = '{20'd123456,  24'h123456, 1'b0};
        tbl[2] = '{20'd999999,  24'h999999, 1'b0};
        tbl[3] = '{20'd1000000, 24'h999999, 1'b1};
        tbl[4] = '{20'd42,      24'h000042, 1'b0};
        tbl[5] = '{20'd1048575, 24'h999999, 1'b1};
        tbl[6] = '{20'd9,       24'h000009, 1'b0};
        tbl[7] = '{20'd10,      24'h000010, 1'b0};
        tbl[8] = '{20'd99999,   24'h099999, 1'b0};
        tbl[9] = '{20'd100000,  24'h100000, 1'b0};

        repeat (3) tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset bcd", 64'(bcd), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            convert(tbl[i].b, $sformatf("tbl%0d", i));
            vectors++;
            if (bcd !== tbl[i].e || ovf !== tbl[i].o) begin
                miscompares++;
                $display("FAIL tbl%0d table: got %h/%0b expected %h/%0b", i, bcd, ovf, tbl[i].e, tbl[i].o);
            end
        end

        for (int i = 0; i < 20; i++) begin
            r = (i % 2 == 0) ? 20'($urandom_range(0, 1048575)) : 20'($urandom_range(999990, 1000010));
            convert(r, $sformatf("rand%0d(%0d)", i, r));
        end

        // start pulses mid-conversion and in the DONE cycle must be ignored
        start = 1'b1;
        bin = 20'd500;
        tick();
        dn = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) dn++;
            start = (k == 5) || done;
            bin = start ? 20'd777 : 20'd0;
            tick();
        end
        start = 1'b0;
        check("ignore done_count", 64'(dn), 64'd1);
        check("ignore bcd", 64'(bcd), 64'h000500);
        check("ignore busy", 64'(busy), 64'd0);

        // reset in cycle 10 of CONV discards the conversion
        start = 1'b1;
        bin = 20'd654321;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("midreset busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset bcd", 64'(bcd), 64'd0);
        check("midreset ovf", 64'(ovf), 64'd0);
        reset = 1'b1;
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) dn++;
            tick();
        end
        check("midreset no_done", 64'(dn), 64'd0);

        // start held high: one conversion per 22 cycles
        start = 1'b1;
        bin = 20'd1;
        last_t = -1;
        n_done = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done) begin
                n_done++;
                check("cont bcd", 64'(bcd), 64'h000001);
                check("cont ovf", 64'(ovf), 64'd0);
                if (last_t >= 0) check("cont period", 64'(k - last_t), 64'd22);
                last_t = k;
            end
        end
        start = 1'b0;
        check("cont pulses", 64'(n_done), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
